// File: rtl/dac_playback_pkg.sv
// Shared types and default widths for the DAC waveform playback sequencer.
package dac_playback_pkg;

    localparam int DAC_DW     = 10;
    localparam int DAC_MEM_AW = 8;
    localparam int DAC_LOOP_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PUSH,
        GAP,
        DRAIN
    } state_t;

endpackage

// File: rtl/dac_playback_ctrl_wave_ram.sv
// Waveform sample store: one write port, one synchronous read port.
// On a same-address read/write collision the read returns the old data.
module wave_ram #(
    parameter int AW = 8,
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Both ports update with non-blocking assignments, so a read sees the
    // array contents from before a write on the same edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dac_playback_ctrl.sv
// Playback sequencer: streams a RAM address window into the DAC FIFO a
// programmed number of times, pacing pushes on the FIFO low flag.
module dac_playback_ctrl
    import dac_playback_pkg::*;
#(
    parameter int MEM_AW = DAC_MEM_AW,
    parameter int DW     = DAC_DW,
    parameter int LOOP_W = DAC_LOOP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wave_we,
    input  logic [MEM_AW-1:0] wave_waddr,
    input  logic [DW-1:0]     wave_wdata,
    input  logic              start,
    input  logic              stop,
    input  logic [MEM_AW-1:0] start_addr,
    input  logic [MEM_AW-1:0] end_addr,
    input  logic [LOOP_W-1:0] loop_count,
    input  logic              dac_low,
    input  logic              dac_empty,
    output logic              dac_wr,
    output logic [DW-1:0]     dac_data,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic [LOOP_W-1:0] loops_done
);

    state_t            state;
    logic [MEM_AW-1:0] ptr;
    logic [MEM_AW-1:0] start_lat;
    logic [MEM_AW-1:0] end_lat;
    logic [LOOP_W-1:0] loop_lat;
    logic              final_pass;
    logic              pushed_once;
    logic [DW-1:0]     ram_q;
    logic              ram_re;

    logic              wrap;
    logic [MEM_AW-1:0] ptr_next;
    logic [LOOP_W-1:0] loops_next;
    logic              final_next;

    assign ram_re = (state == FETCH);
    assign busy   = (state != IDLE);

    wave_ram #(
        .AW (MEM_AW),
        .DW (DW)
    ) u_wave_ram (
        .clk   (clk),
        .we    (wave_we),
        .waddr (wave_waddr),
        .wdata (wave_wdata),
        .re    (ram_re),
        .raddr (ptr),
        .rdata (ram_q)
    );

    // Pointer advance; natural modulo wrap covers windows that cross the top of RAM.
    always_comb begin
        wrap       = (ptr == end_lat);
        ptr_next   = ptr + MEM_AW'(1);
        loops_next = loops_done;
        final_next = 1'b0;
        if (wrap) begin
            ptr_next = start_lat;
            if (loops_done != '1) begin
                loops_next = loops_done + LOOP_W'(1);
            end
            final_next = (loop_lat != '0) && (loops_next == loop_lat);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            start_lat   <= '0;
            end_lat     <= '0;
            loop_lat    <= '0;
            final_pass  <= 1'b0;
            pushed_once <= 1'b0;
            dac_wr      <= 1'b0;
            dac_data    <= '0;
            done        <= 1'b0;
            underrun    <= 1'b0;
            loops_done  <= '0;
        end else begin
            dac_wr <= 1'b0;
            done   <= 1'b0;

            if (state != IDLE && stop) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            start_lat   <= start_addr;
                            end_lat     <= end_addr;
                            loop_lat    <= loop_count;
                            ptr         <= start_addr;
                            loops_done  <= '0;
                            underrun    <= 1'b0;
                            final_pass  <= 1'b0;
                            pushed_once <= 1'b0;
                            state       <= FETCH;
                        end
                    end
                    FETCH: begin
                        state <= PUSH;
                    end
                    PUSH: begin
                        if (dac_low) begin
                            dac_wr      <= 1'b1;
                            dac_data    <= ram_q;
                            ptr         <= ptr_next;
                            loops_done  <= loops_next;
                            final_pass  <= final_next;
                            pushed_once <= 1'b1;
                            state       <= GAP;
                        end
                    end
                    GAP: begin
                        state <= final_pass ? DRAIN : FETCH;
                    end
                    DRAIN: begin
                        if (dac_empty) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end

            // The FIFO is legitimately empty before the first sample lands.
            if (pushed_once && dac_empty &&
                (state == FETCH || state == PUSH || state == GAP)) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Scoreboard bench for dac_playback_ctrl: expected samples are queued from a
// RAM model when playback is started and popped as dac_wr pulses appear.
module tb_dac_playback_ctrl;

    localparam int MEM_AW = 8;
    localparam int DW     = 10;
    localparam int LOOP_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wave_we = 1'b0;
    logic [MEM_AW-1:0] wave_waddr = '0;
    logic [DW-1:0]     wave_wdata = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [MEM_AW-1:0] start_addr = '0;
    logic [MEM_AW-1:0] end_addr = '0;
    logic [LOOP_W-1:0] loop_count = '0;
    logic              dac_low = 1'b0;
    logic              dac_empty = 1'b0;
    logic              dac_wr;
    logic [DW-1:0]     dac_data;
    logic              busy;
    logic              done;
    logic              underrun;
    logic [LOOP_W-1:0] loops_done;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] model_ram [256];

    dac_playback_ctrl #(
        .MEM_AW (MEM_AW),
        .DW     (DW),
        .LOOP_W (LOOP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wave_we    (wave_we),
        .wave_waddr (wave_waddr),
        .wave_wdata (wave_wdata),
        .start      (start),
        .stop       (stop),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .loop_count (loop_count),
        .dac_low    (dac_low),
        .dac_empty  (dac_empty),
        .dac_wr     (dac_wr),
        .dac_data   (dac_data),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun),
        .loops_done (loops_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_ram(input logic [MEM_AW-1:0] a, input logic [DW-1:0] d);
        wave_we    = 1'b1;
        wave_waddr = a;
        wave_wdata = d;
        @(negedge clk);
        wave_we = 1'b0;
        model_ram[a] = d;
    endtask

    task automatic queue_window(input logic [MEM_AW-1:0] s, input logic [MEM_AW-1:0] e,
                                input int passes);
        logic [MEM_AW-1:0] a;
        for (int p = 0; p < passes; p++) begin
            a = s;
            for (int k = 0; k < 256; k++) begin
                exp_q.push_back(model_ram[a]);
                if (a == e) break;
                a = a + 8'd1;
            end
        end
    endtask

    task automatic pulse_start(input logic [MEM_AW-1:0] s, input logic [MEM_AW-1:0] e,
                               input logic [LOOP_W-1:0] lc);
        start_addr = s;
        end_addr   = e;
        loop_count = lc;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_push(input int budget, output bit got, output logic [DW-1:0] data,
                             output int waited);
        got    = 1'b0;
        data   = '0;
        waited = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            waited++;
            if (dac_wr === 1'b1) begin
                got  = 1'b1;
                data = dac_data;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [DW-1:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        total++;
        if ({dac_wr, busy, done, underrun} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b expected 0000", {dac_wr, busy, done, underrun});
        else passed++;
        total++;
        if (dac_data !== '0 || loops_done !== '0)
            $display("[TB] FAIL reset_data: got data=%h loops=%0d expected 0/0", dac_data, loops_done);
        else passed++;
        rst_n = 1'b1;
        tick(2);
        total++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_idle: busy got %b expected 0", busy);
        else passed++;
    endtask

    task automatic test_basic_loop();
        bit got;
        logic [DW-1:0] data, exp;
        int waited, last_cyc;
        write_ram(8'h00, 10'h001);
        write_ram(8'h01, 10'h002);
        write_ram(8'h02, 10'h003);
        write_ram(8'h03, 10'h3FF);
        dac_low   = 1'b1;
        dac_empty = 1'b1;
        exp_q.delete();
        queue_window(8'h00, 8'h03, 2);
        pulse_start(8'h00, 8'h03, 16'd2);
        last_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            wait_push(12, got, data, waited);
            exp = pop_exp();
            total++;
            if (!got) $display("[TB] FAIL basic_push%0d: timed out, expected %h", i, exp);
            else if (data !== exp) $display("[TB] FAIL basic_push%0d: got %h expected %h", i, data, exp);
            else passed++;
            if (i == 0) begin
                dac_empty = 1'b0;
                total++;
                if (waited != 2) $display("[TB] FAIL basic_latency: got %0d expected 2", waited);
                else passed++;
            end else begin
                total++;
                if (cyc - last_cyc != 3)
                    $display("[TB] FAIL basic_spacing%0d: got %0d expected 3", i, cyc - last_cyc);
                else passed++;
            end
            last_cyc = cyc;
        end
        tick(5);
        total++;
        if ({busy, done} !== 2'b10) $display("[TB] FAIL basic_drain_hold: got %b expected 10", {busy, done});
        else passed++;
        dac_empty = 1'b1;
        wait_done(10, got);
        total++;
        if (!got) $display("[TB] FAIL basic_done: got none expected pulse");
        else passed++;
        total++;
        if (loops_done !== 16'd2 || busy !== 1'b0)
            $display("[TB] FAIL basic_loops: got loops=%0d busy=%b expected 2/0", loops_done, busy);
        else passed++;
        tick(1);
        total++;
        if (done !== 1'b0 || underrun !== 1'b0)
            $display("[TB] FAIL basic_after: got done=%b underrun=%b expected 0/0", done, underrun);
        else passed++;
        total++;
        if (exp_q.size() != 0) $display("[TB] FAIL basic_queue: got %0d left expected 0", exp_q.size());
        else passed++;
        dac_empty = 1'b0;
    endtask

    task automatic test_backpressure();
        bit got;
        logic [DW-1:0] data, exp;
        int waited, wr_cnt, idle_cnt;
        dac_low   = 1'b1;
        dac_empty = 1'b0;
        exp_q.delete();
        queue_window(8'h00, 8'h03, 1);
        pulse_start(8'h00, 8'h03, 16'd1);
        wait_push(12, got, data, waited);
        exp = pop_exp();
        total++;
        if (!got || data !== exp) $display("[TB] FAIL bp_first: got %h expected %h", data, exp);
        else passed++;
        dac_low = 1'b0;
        write_ram(8'h03, 10'h155);
        exp_q[exp_q.size()-1] = 10'h155;
        wr_cnt   = 0;
        idle_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (dac_wr) wr_cnt++;
            if (!busy) idle_cnt++;
        end
        total++;
        if (wr_cnt != 0 || idle_cnt != 0)
            $display("[TB] FAIL bp_stall: got wr=%0d idle=%0d expected 0/0", wr_cnt, idle_cnt);
        else passed++;
        dac_low = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_push(12, got, data, waited);
            exp = pop_exp();
            total++;
            if (!got || data !== exp) $display("[TB] FAIL bp_push%0d: got %h expected %h", i, data, exp);
            else passed++;
            if (i == 0) begin
                total++;
                if (waited != 1) $display("[TB] FAIL bp_release: got %0d expected 1", waited);
                else passed++;
            end
        end
        dac_empty = 1'b1;
        wait_done(10, got);
        total++;
        if (!got || loops_done !== 16'd1)
            $display("[TB] FAIL bp_done: got done=%b loops=%0d expected 1/1", got, loops_done);
        else passed++;
        dac_empty = 1'b0;
        write_ram(8'h03, 10'h3FF);
    endtask

    task automatic test_wrap_window();
        bit got;
        logic [DW-1:0] data, exp;
        int waited;
        write_ram(8'hFE, 10'h2FE);
        write_ram(8'hFF, 10'h2FF);
        write_ram(8'h00, 10'h100);
        write_ram(8'h01, 10'h101);
        dac_low   = 1'b1;
        dac_empty = 1'b0;
        exp_q.delete();
        queue_window(8'hFE, 8'h01, 1);
        pulse_start(8'hFE, 8'h01, 16'd1);
        for (int i = 0; i < 4; i++) begin
            wait_push(12, got, data, waited);
            exp = pop_exp();
            total++;
            if (!got || data !== exp) $display("[TB] FAIL wrap_push%0d: got %h expected %h", i, data, exp);
            else passed++;
        end
        dac_empty = 1'b1;
        wait_done(10, got);
        total++;
        if (!got || loops_done !== 16'd1)
            $display("[TB] FAIL wrap_done: got done=%b loops=%0d expected 1/1", got, loops_done);
        else passed++;
        dac_empty = 1'b0;
    endtask

    task automatic test_infinite_stop();
        bit got;
        logic [DW-1:0] data, exp;
        int waited, wr_cnt, done_cnt;
        dac_low   = 1'b1;
        dac_empty = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(model_ram[i % 4]);
        pulse_start(8'h00, 8'h03, 16'd0);
        for (int i = 0; i < 10; i++) begin
            wait_push(12, got, data, waited);
            exp = pop_exp();
            total++;
            if (!got || data !== exp) $display("[TB] FAIL inf_push%0d: got %h expected %h", i, data, exp);
            else passed++;
        end
        pulse_stop();
        total++;
        if (busy !== 1'b0) $display("[TB] FAIL stop_busy: got %b expected 0", busy);
        else passed++;
        wr_cnt   = 0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (dac_wr) wr_cnt++;
            if (done) done_cnt++;
        end
        total++;
        if (wr_cnt != 0 || done_cnt != 0)
            $display("[TB] FAIL stop_quiet: got wr=%0d done=%0d expected 0/0", wr_cnt, done_cnt);
        else passed++;
        total++;
        if (loops_done !== 16'd2) $display("[TB] FAIL stop_loops: got %0d expected 2", loops_done);
        else passed++;
    endtask

    task automatic test_underrun();
        bit got;
        logic [DW-1:0] data;
        int waited;
        dac_low   = 1'b1;
        dac_empty = 1'b0;
        pulse_start(8'h00, 8'h03, 16'd1);
        wait_push(12, got, data, waited);
        total++;
        if (!got || underrun !== 1'b0)
            $display("[TB] FAIL ur_before: got push=%b underrun=%b expected 1/0", got, underrun);
        else passed++;
        dac_low = 1'b0;
        tick(3);
        dac_empty = 1'b1;
        tick(1);
        dac_empty = 1'b0;
        total++;
        if (underrun !== 1'b1) $display("[TB] FAIL ur_set: got %b expected 1", underrun);
        else passed++;
        tick(10);
        pulse_stop();
        total++;
        if (underrun !== 1'b1 || busy !== 1'b0)
            $display("[TB] FAIL ur_sticky: got underrun=%b busy=%b expected 1/0", underrun, busy);
        else passed++;
        pulse_start(8'h00, 8'h03, 16'd1);
        total++;
        if (underrun !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL ur_clear: got underrun=%b busy=%b expected 0/1", underrun, busy);
        else passed++;
        pulse_stop();
    endtask

    task automatic test_start_conflict();
        bit got;
        logic [DW-1:0] data, exp;
        int waited, busy_cnt;
        start    = 1'b1;
        stop     = 1'b1;
        tick(1);
        start    = 1'b0;
        stop     = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy) busy_cnt++;
            tick(1);
        end
        total++;
        if (busy_cnt != 0) $display("[TB] FAIL startstop_busy: got %0d busy cycles expected 0", busy_cnt);
        else passed++;
        dac_low   = 1'b0;
        dac_empty = 1'b0;
        exp_q.delete();
        queue_window(8'h00, 8'h03, 1);
        pulse_start(8'h00, 8'h03, 16'd1);
        tick(2);
        pulse_start(8'hFE, 8'h01, 16'd5);
        tick(2);
        dac_low = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_push(12, got, data, waited);
            exp = pop_exp();
            total++;
            if (!got || data !== exp) $display("[TB] FAIL busy_start_push%0d: got %h expected %h", i, data, exp);
            else passed++;
        end
        dac_empty = 1'b1;
        wait_done(10, got);
        total++;
        if (!got || loops_done !== 16'd1)
            $display("[TB] FAIL busy_start_done: got done=%b loops=%0d expected 1/1", got, loops_done);
        else passed++;
        dac_empty = 1'b0;
    endtask

    task automatic test_reset_midop();
        bit got;
        logic [DW-1:0] data;
        int waited, n;
        dac_low   = 1'b1;
        dac_empty = 1'b0;
        pulse_start(8'h00, 8'h03, 16'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            wait_push(12, got, data, waited);
            if (got) n++;
        end
        total++;
        if (n != 6 || loops_done !== 16'd1 || dac_wr !== 1'b1)
            $display("[TB] FAIL midop_pre: got pushes=%0d loops=%0d expected 6/1", n, loops_done);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({dac_wr, busy, done, underrun} !== 4'b0000 || dac_data !== '0 || loops_done !== '0)
            $display("[TB] FAIL midop_reset: got flags=%b data=%h loops=%0d expected 0000/000/0",
                     {dac_wr, busy, done, underrun}, dac_data, loops_done);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        total++;
        if (busy !== 1'b0 || dac_wr !== 1'b0)
            $display("[TB] FAIL midop_after: got busy=%b wr=%b expected 0/0", busy, dac_wr);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_loop();
        test_backpressure();
        test_wrap_window();
        test_infinite_stop();
        test_underrun();
        test_start_conflict();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
